// File: rtl/comp_pkg.sv
// Shared types and constants for the nibble-serial magnitude comparator.
package comp_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Cascade flag triple carried between nibble steps.
  typedef struct packed {
    logic e;
    logic g;
    logic l;
  } flags_t;

  // Starting point of every comparison: "equal so far".
  localparam flags_t FLAGS_EQ = '{e: 1'b1, g: 1'b0, l: 1'b0};

endpackage

// File: rtl/comp4_ins.sv
// 4-bit cascade comparator stage. A decision on this nibble overrides the
// incoming flags; equal nibbles pass the incoming flags through.
module comp4_ins
  import comp_pkg::*;
(
  input  logic                e,
  input  logic                g,
  input  logic                l,
  input  logic [NIBBLE_W-1:0] A,
  input  logic [NIBBLE_W-1:0] B,
  output logic                Fe,
  output logic                Fg,
  output logic                Fl
);

  // Resolve this nibble, deferring to the lower-nibble result on a tie.
  always_comb begin
    Fe = e;
    Fg = g;
    Fl = l;
    if (A > B) begin
      Fe = 1'b0;
      Fg = 1'b1;
      Fl = 1'b0;
    end else if (A < B) begin
      Fe = 1'b0;
      Fg = 1'b0;
      Fl = 1'b1;
    end
  end

endmodule

// File: rtl/comp12_serial.sv
// Nibble-serial unsigned magnitude comparator: one cascade stage reused
// LSB nibble first, flags carried in registers between cycles.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for an operand pair; in_ready=1
// RUN   | one nibble per cycle through the cascade stage, LSB first
// DONE  | result held on Fe/Fg/Fl with out_valid=1 until out_ready
module comp12_serial
  import comp_pkg::*;
#(
  parameter int NIBBLES = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0] A,
  input  logic [NIBBLE_W*NIBBLES-1:0] B,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        Fe,
  output logic                        Fg,
  output logic                        Fl
);

  localparam int W     = NIBBLE_W * NIBBLES;
  // Keep at least one counter bit so NIBBLES=1 still elaborates.
  localparam int CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIBBLES - 1);

  state_t           state;
  logic [W-1:0]     sh_a;
  logic [W-1:0]     sh_b;
  logic [CNT_W-1:0] cnt;
  flags_t           flags;
  flags_t           stage;

  comp4_ins u_stage (
    .e  (flags.e),
    .g  (flags.g),
    .l  (flags.l),
    .A  (sh_a[NIBBLE_W-1:0]),
    .B  (sh_b[NIBBLE_W-1:0]),
    .Fe (stage.e),
    .Fg (stage.g),
    .Fl (stage.l)
  );

  // Sequencer: accept operands, step one nibble per cycle, hold result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      Fe        <= 1'b0;
      Fg        <= 1'b0;
      Fl        <= 1'b0;
      cnt       <= '0;
      sh_a      <= '0;
      sh_b      <= '0;
      flags     <= FLAGS_EQ;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sh_a     <= A;
            sh_b     <= B;
            flags    <= FLAGS_EQ;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          flags <= stage;
          sh_a  <= sh_a >> NIBBLE_W;
          sh_b  <= sh_b >> NIBBLE_W;
          if (cnt == CNT_LAST) begin
            // Last (most significant) nibble: publish the final decision.
            Fe        <= stage.e;
            Fg        <= stage.g;
            Fl        <= stage.l;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/comp12_serial.md
# comp12_serial

Nibble-serial magnitude comparator for two 12-bit unsigned operands. It is the time-multiplexed counterpart of the combinational cascaded comparator. A single 4-bit cascade stage is reused once per cycle, LSB nibble first, with the equal/greater/less cascade flags carried in registers between cycles. Operands enter and results leave through valid/ready handshakes. The block sits between an operand producer and a result consumer that can tolerate multi-cycle latency in exchange for one comparator stage instead of three.

## Interface
- NIBBLES, 3, number of 4-bit nibbles per operand; operand width is 4*NIBBLES (12 at default); legal range 1..8
- clk  input  1  clock; all state changes on the rising edge
- rst  input  1  reset; synchronous and active-high
- in_valid  input  1  operand pair A/B is presented
- in_ready  output  1  block accepts an operand pair this cycle
- A  input  4*NIBBLES  unsigned operand A; sampled only on accept
- B  input  4*NIBBLES  unsigned operand B; sampled only on accept
- out_valid  output  1  Fe/Fg/Fl hold a completed result
- out_ready  input  1  consumer takes the result this cycle
- Fe  output  1  A == B
- Fg  output  1  A > B
- Fl  output  1  A < B

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&in_ready: load A and B into shift registers, set cascade flags to e=1 g=0 l=0, clear the nibble counter, go to RUN.
- RUN:
  - Each cycle, compare the current low nibbles of the shift registers through the cascade stage using the registered flags.
  - Stage rule: nibble A>B gives g=1; nibble A<B gives l=1; nibbles equal pass the input flags through unchanged.
  - Register the new flags, shift both registers right by 4, increment the counter.
  - When the counter reaches NIBBLES-1, the comparison finishes that cycle and the state goes to DONE.
- DONE:
  - out_valid=1. Fe/Fg/Fl equal the registered flags and are exactly one-hot.
  - On out_ready=1, go to IDLE.
- in_ready=0 in RUN and DONE. in_valid outside IDLE is ignored and does not change A or B.
- Outputs are stable while out_valid=1 and out_ready=0.
- After handshake, Fe/Fg/Fl keep their last value. They are meaningful only when out_valid=1.
- Operands are unsigned and there is no overflow path. The higher-nibble decision always overrides the lower-nibble decision.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, Fe=0, Fg=0, Fl=0, counter=0, shift registers=0.
- Latency: with accept in cycle 0, RUN covers cycles 1..NIBBLES and out_valid rises in cycle NIBBLES+1 (cycle 4 at default).
- Throughput: at best one result per NIBBLES+2 cycles (IDLE, NIBBLES RUN cycles, DONE with out_ready=1).
- Out-of-range NIBBLES: not supported.
- Boundary conditions:
  - out_ready held high before DONE: result is consumed in its first DONE cycle; out_valid is high for exactly 1 cycle.
  - out_ready low: the block stalls in DONE indefinitely. in_ready stays 0 and no new operands are taken.
  - rst asserted in any state, including mid-RUN or DONE: the in-flight comparison is discarded and all values return to reset on the next edge. No result is emitted for the aborted operation.
  - rst and in_valid in the same cycle: rst wins and nothing is accepted.
  - Counter wrap: the counter clears on every accept. It never wraps within an operation.

## Structure
- Shared package comp_pkg:
  - State enum: IDLE/RUN/DONE.
  - Constant NIBBLE_W=4.
  - Flag-triple type {e,g,l} with its reset constant FLAGS_EQ = {1,0,0}.
- One sub-module: comp4_ins, the existing 4-bit cascade stage (ports e, g, l, A, B, Fe, Fg, Fl), instantiated once.
- Top-level logic, all in this block: FSM, counter, shift registers, flag registers.

## Test plan
- Reset, then A=0xABC, B=0xABC, out_ready=1 -> out_valid in cycle 4 after accept for exactly 1 cycle; Fe=1 Fg=0 Fl=0.
- A=0x800, B=0x7FF -> Fg=1. The MSB nibble decision overrides the lower nibbles, where B is larger.
- A=0x123, B=0x124 -> Fl=1. Only the LSB nibble differs.
- A=0x0F0, B=0x0E0 with out_ready=0 for 5 cycles in DONE:
  - Fg=1 held stable and out_valid held for 5 cycles.
  - in_ready=0 throughout; a different A/B with in_valid=1 in that window is not sampled.
  - out_ready=1 -> IDLE the next cycle.
- rst pulsed in the 2nd RUN cycle of A=0xFFF, B=0x000 -> next cycle: IDLE, out_valid=0, Fe=Fg=Fl=0. A following A=0x001, B=0x001 -> Fe=1 with the nominal latency.
- Back-to-back accepts with in_valid and out_ready tied high -> accepts spaced exactly 5 cycles apart. A random sweep of 1000 pairs matches a reference compare.
